// File: rtl/sys_defs.sv
// Shared reorder-buffer types: the dispatch packet, the stored entry and the retire packet.
package sys_defs;
    localparam int XLEN  = 32;
    localparam int TAG_W = 6;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef logic [TAG_W-1:0] TAG;

    typedef struct packed {
        TAG              t;
        TAG              t_old;
        logic [31:0]     inst;
        logic            halt;
        logic            wr_mem;
        logic [4:0]      dest_reg_idx;
        logic [XLEN-1:0] npc;
    } ROB_DISP_PKT;

    typedef struct packed {
        TAG              t;
        TAG              t_old;
        logic [31:0]     inst;
        logic            halt;
        logic            wr_mem;
        logic [4:0]      dest_reg_idx;
        logic [XLEN-1:0] npc;
        logic            completed;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] rs2;
        logic            take_branch;
        logic            mispredict;
    } ROB_ENTRY;

    typedef ROB_ENTRY ROB_RET_PKT;

    function automatic ROB_ENTRY new_entry(input ROB_DISP_PKT p);
        ROB_ENTRY e;
        e              = '0;
        e.t            = p.t;
        e.t_old        = p.t_old;
        e.inst         = p.inst;
        e.halt         = p.halt;
        e.wr_mem       = p.wr_mem;
        e.dest_reg_idx = p.dest_reg_idx;
        e.npc          = p.npc;
        return e;
    endfunction

    function automatic ROB_RET_PKT nop_ret_pkt();
        ROB_RET_PKT r;
        r      = '0;
        r.inst = NOP_INST;
        return r;
    endfunction
endpackage

// File: rtl/rob_retire_sel.sv
// Prefix scan over the head lanes: a lane retires only if every older lane retires
// and no older retiring lane carries a mispredict.
module rob_retire_sel #(
    parameter int WIDTH = 2,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic             en,
    input  logic [WIDTH-1:0] ready,
    input  logic [WIDTH-1:0] mispredict,
    output logic [WIDTH-1:0] ret_valid,
    output logic [CW-1:0]    ret_cnt
);
    always_comb begin
        logic run;
        run       = en;
        ret_valid = '0;
        ret_cnt   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            run          = run & ready[k];
            ret_valid[k] = run;
            if (run) ret_cnt = ret_cnt + CW'(1);
            run          = run & ~mispredict[k];
        end
    end
endmodule

// File: rtl/rob_ss.sv
// Reorder buffer: in-order dispatch and retire of WIDTH lanes, CDB_N completion ports,
// and a one-cycle registered squash when a mispredicted entry retires.
module rob_ss
    import sys_defs::*;
#(
    parameter int ROB_SZ = 32,
    parameter int WIDTH  = 2,
    parameter int CDB_N  = 2,
    localparam int IDX   = $clog2(ROB_SZ),
    localparam int CNT_W = IDX + 1,
    localparam int FS_W  = $clog2(WIDTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            interrupt,
    input  logic            retire_stall,
    input  logic [WIDTH-1:0] disp_valid,
    input  ROB_DISP_PKT     disp_pkt [WIDTH],
    output logic [FS_W-1:0] free_slots,
    output logic [IDX-1:0]  disp_idx [WIDTH],
    input  logic [CDB_N-1:0] cmp_valid,
    input  logic [IDX-1:0]  cmp_idx [CDB_N],
    input  logic [XLEN-1:0] cmp_result [CDB_N],
    input  logic [XLEN-1:0] cmp_rs2 [CDB_N],
    input  logic [CDB_N-1:0] cmp_take_branch,
    input  logic [CDB_N-1:0] cmp_mispredict,
    output logic [WIDTH-1:0] ret_valid,
    output ROB_RET_PKT      ret_pkt [WIDTH],
    output logic            squash,
    output logic [XLEN-1:0] squash_npc
);
    ROB_ENTRY         entries [ROB_SZ];
    logic [IDX-1:0]   head;
    logic [IDX-1:0]   tail;
    logic [CNT_W-1:0] count;

    logic [CNT_W-1:0] space;
    logic [WIDTH-1:0] accept;
    logic [FS_W-1:0]  acc_cnt;
    logic [WIDTH-1:0] ready;
    logic [WIDTH-1:0] lane_misp;
    logic [FS_W-1:0]  ret_cnt;
    logic             squash_next;
    logic [XLEN-1:0]  npc_next;

    // Occupancy is derived from head/count, so retired slots need no explicit clearing.
    function automatic logic occupied(input logic [IDX-1:0] idx);
        logic [IDX-1:0] off;
        off = idx - head;
        return {1'b0, off} < count;
    endfunction

    assign space      = CNT_W'(ROB_SZ) - count;
    assign free_slots = (space > CNT_W'(WIDTH)) ? FS_W'(WIDTH) : FS_W'(space);

    for (genvar g = 0; g < WIDTH; g++) begin : g_idx
        assign disp_idx[g] = tail + IDX'(g);
    end

    always_comb begin
        accept  = '0;
        acc_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (disp_valid[i] && (FS_W'(i) < free_slots) && !squash) begin
                accept[i] = 1'b1;
                acc_cnt   = acc_cnt + FS_W'(1);
            end
        end
    end

    always_comb begin
        ready     = '0;
        lane_misp = '0;
        for (int k = 0; k < WIDTH; k++) begin
            ready[k]     = occupied(head + IDX'(k)) && entries[head + IDX'(k)].completed;
            lane_misp[k] = entries[head + IDX'(k)].mispredict;
        end
    end

    rob_retire_sel #(.WIDTH(WIDTH)) u_retire_sel (
        .en         (!retire_stall && !squash),
        .ready      (ready),
        .mispredict (lane_misp),
        .ret_valid  (ret_valid),
        .ret_cnt    (ret_cnt)
    );

    always_comb begin
        squash_next = 1'b0;
        npc_next    = '0;
        for (int k = 0; k < WIDTH; k++) begin
            ret_pkt[k] = nop_ret_pkt();
            if (ret_valid[k]) begin
                ret_pkt[k] = entries[head + IDX'(k)];
                if (entries[head + IDX'(k)].mispredict) begin
                    squash_next = 1'b1;
                    npc_next    = entries[head + IDX'(k)].take_branch ?
                                  entries[head + IDX'(k)].result : entries[head + IDX'(k)].npc;
                end
            end
        end
    end

    // State update: reset/interrupt and the squash cycle both empty the buffer.
    always_ff @(posedge clock) begin
        if (reset || interrupt || squash) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            squash <= 1'b0;
            for (int i = 0; i < ROB_SZ; i++) begin
                entries[i].completed  <= 1'b0;
                entries[i].mispredict <= 1'b0;
            end
            if (reset || interrupt) squash_npc <= '0;
        end else begin
            head   <= head + IDX'(ret_cnt);
            tail   <= tail + IDX'(acc_cnt);
            count  <= count + CNT_W'(acc_cnt) - CNT_W'(ret_cnt);
            squash <= squash_next;
            if (squash_next) squash_npc <= npc_next;
            for (int c = 0; c < CDB_N; c++) begin
                if (cmp_valid[c] && occupied(cmp_idx[c])) begin
                    entries[cmp_idx[c]].completed   <= 1'b1;
                    entries[cmp_idx[c]].result      <= cmp_result[c];
                    entries[cmp_idx[c]].rs2         <= cmp_rs2[c];
                    entries[cmp_idx[c]].take_branch <= cmp_take_branch[c];
                    entries[cmp_idx[c]].mispredict  <= cmp_mispredict[c];
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (accept[i]) entries[disp_idx[i]] <= new_entry(disp_pkt[i]);
            end
        end
    end
endmodule
